// File: rtl/max_scan_ctrl.sv
// Frame-buffered signed max finder: fills DEPTH samples, then scans them
// with one time-shared comparator and offers the max and its index.
module max_scan_ctrl #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     abort,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_max,
  output logic [$clog2(DEPTH)-1:0] m_idx,
  output logic                     busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    FILL,
    SCAN,
    DONE
  } state_t;

  state_t                   state;
  logic [WIDTH-1:0]         mem [DEPTH];
  logic [IW-1:0]            wr_cnt;
  logic [IW-1:0]            scan_ptr;
  logic signed [WIDTH-1:0]  cur_max;
  logic [IW-1:0]            cur_idx;
  logic                     wr_en;
  logic                     gt;

  assign wr_en = !rst && !abort && s_valid && (state == FILL);
  // the only magnitude comparator; ties keep the earlier index
  assign gt = $signed(mem[scan_ptr]) > cur_max;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_cnt] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      wr_cnt   <= '0;
      scan_ptr <= '0;
      cur_max  <= '0;
      cur_idx  <= '0;
    end else if (abort) begin
      state    <= FILL;
      wr_cnt   <= '0;
      scan_ptr <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (s_valid) begin
            if (wr_cnt == LAST) begin
              state    <= SCAN;
              wr_cnt   <= '0;
              cur_max  <= $signed(mem[0]);
              cur_idx  <= '0;
              scan_ptr <= IW'(1);
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        SCAN: begin
          if (gt) begin
            cur_max <= $signed(mem[scan_ptr]);
            cur_idx <= scan_ptr;
          end
          scan_ptr <= scan_ptr + 1'b1;
          if (scan_ptr == LAST)
            state <= DONE;
        end
        DONE: begin
          if (m_ready) begin
            state    <= FILL;
            wr_cnt   <= '0;
            scan_ptr <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // outputs are forced quiet while rst is held, before any edge lands
  assign s_ready = !rst && (state == FILL);
  assign m_valid = !rst && (state == DONE);
  assign busy    = !rst && (state != FILL);
  assign m_max   = m_valid ? cur_max : '0;
  assign m_idx   = m_valid ? cur_idx : '0;

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Bench for max_scan_ctrl: directed frames plus random frames checked
// against a plain arithmetic max/argmax model.
module tb_max_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [8:0] s_data;
  logic       abort;
  logic       m_valid;
  logic       m_ready;
  logic [8:0] m_max;
  logic [1:0] m_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  max_scan_ctrl #(.WIDTH(9), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .abort(abort),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_max(m_max), .m_idx(m_idx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sx(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  task automatic ref_max(input int s[4], output int mx, output int ix);
    mx = s[0];
    ix = 0;
    for (int i = 1; i < 4; i++)
      if (s[i] > mx) begin
        mx = s[i];
        ix = i;
      end
  endtask

  // Sends a frame, waits (bounded) for m_valid; returns edges after last accept.
  task automatic run_frame(input int s[4], input logic mr,
                           output int lat, output int mx, output int ix);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 9'(s[i]);
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = mr;
    #1;
    lat = 0;
    while (m_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    mx = sx(m_max);
    ix = int'(m_idx);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: s_ready=%b m_valid=%b busy=%b want 0 0 0",
               s_ready, m_valid, busy);
    end
    @(negedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 ||
        m_max !== 9'd0 || m_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b m_valid=%b busy=%b max=%h idx=%0d",
               s_ready, m_valid, busy, m_max, m_idx);
    end
  endtask

  task automatic test_basic;
    int s[4] = '{5, -3, 100, 7};
    int lat, mx, ix;
    run_frame(s, 1'b1, lat, mx, ix);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 3", lat);
    end
    checks++;
    if (mx !== 100 || ix !== 2) begin
      errors++;
      $display("FAIL basic_result: got max=%0d idx=%0d want 100 2", mx, ix);
    end
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_flags: busy=%b s_ready=%b want 1 0", busy, s_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_max !== 9'd0) begin
      errors++;
      $display("FAIL basic_single_cycle: m_valid=%b s_ready=%b max=%h",
               m_valid, s_ready, m_max);
    end
  endtask

  task automatic test_ties;
    int f[3][4] = '{'{-10, -2, -256, -2},
                    '{255, 255, 255, 255},
                    '{-256, -256, -256, -255}};
    int wmx[3] = '{-2, 255, -255};
    int wix[3] = '{1, 0, 3};
    int lat, mx, ix;
    for (int k = 0; k < 3; k++) begin
      run_frame(f[k], 1'b1, lat, mx, ix);
      checks++;
      if (lat !== 3 || mx !== wmx[k] || ix !== wix[k]) begin
        errors++;
        $display("FAIL ties_%0d: got lat=%0d max=%0d idx=%0d want 3 %0d %0d",
                 k, lat, mx, ix, wmx[k], wix[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int s[4] = '{-7, 33, 33, -100};
    int lat, mx, ix;
    run_frame(s, 1'b0, lat, mx, ix);
    checks++;
    if (lat !== 3 || mx !== 33 || ix !== 1) begin
      errors++;
      $display("FAIL bp_result: got lat=%0d max=%0d idx=%0d want 3 33 1", lat, mx, ix);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b1 || sx(m_max) !== 33 || m_idx !== 2'd1 ||
          s_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: m_valid=%b max=%0d idx=%0d s_ready=%b",
                 c, m_valid, sx(m_max), m_idx, s_ready);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: m_valid=%b s_ready=%b busy=%b", m_valid, s_ready, busy);
    end
  endtask

  task automatic test_abort;
    int s[4] = '{1, 2, 3, 4};
    int lat, mx, ix;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 9'd200;
    @(negedge clk);
    s_data  = 9'd150;
    @(negedge clk);
    s_data  = 9'd250;
    abort   = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: s_ready=%b busy=%b m_valid=%b", s_ready, busy, m_valid);
    end
    run_frame(s, 1'b1, lat, mx, ix);
    checks++;
    if (lat !== 3 || mx !== 4 || ix !== 3) begin
      errors++;
      $display("FAIL abort_frame: got lat=%0d max=%0d idx=%0d want 3 4 3", lat, mx, ix);
    end
    @(negedge clk);
  endtask

  task automatic test_abort_done;
    int s[4] = '{0, 1, 0, 0};
    int lat, mx, ix;
    run_frame(s, 1'b0, lat, mx, ix);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_idx !== 2'd0) begin
      errors++;
      $display("FAIL abort_done: m_valid=%b s_ready=%b idx=%0d", m_valid, s_ready, m_idx);
    end
  endtask

  task automatic test_reset_scan;
    int a[4] = '{50, 60, 70, 80};
    int s[4] = '{9, 8, 7, 6};
    int lat, mx, ix;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 9'(a[i]);
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_scan: m_valid=%b busy=%b s_ready=%b", m_valid, busy, s_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_scan_quiet_%0d: m_valid=%b busy=%b", c, m_valid, busy);
      end
    end
    run_frame(s, 1'b1, lat, mx, ix);
    checks++;
    if (lat !== 3 || mx !== 9 || ix !== 0) begin
      errors++;
      $display("FAIL rst_scan_frame: got lat=%0d max=%0d idx=%0d want 3 9 0", lat, mx, ix);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int s[4];
    int lat, mx, ix, emx, eix, hold;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 4; i++)
        s[i] = (f % 3 == 0) ? int'($urandom_range(0, 3)) - 2
                            : int'($urandom_range(0, 511)) - 256;
      ref_max(s, emx, eix);
      hold = int'($urandom_range(0, 3));
      run_frame(s, hold == 0, lat, mx, ix);
      checks++;
      if (lat !== 3 || mx !== emx || ix !== eix) begin
        errors++;
        $display("FAIL rand_%0d: got lat=%0d max=%0d idx=%0d want 3 %0d %0d",
                 f, lat, mx, ix, emx, eix);
      end
      for (int c = 0; c < hold; c++)
        @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_%0d_consume: m_valid=%b s_ready=%b", f, m_valid, s_ready);
      end
      m_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    abort = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_abort();
    test_abort_done();
    test_reset_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
